// File: rtl/tdm_demux_5ch.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_5ch
// Purpose  : Receive-side 1:5 TDM demultiplexer. Collects one WIDTH-bit word
//            per slot (A..E) after a start-of-frame beat into shadow
//            registers, then publishes the complete frame to five output
//            registers in a single cycle together with a frame_valid pulse.
//            A start-of-frame arriving mid-frame drops the partial frame,
//            pulses frame_err and restarts collection with that beat as A.
// Ports    : clk            system clock, rising edge
//            reset          asynchronous active-high reset
//            i_data_in      TDM word for the current slot
//            i_in_valid     i_data_in valid this cycle
//            i_sof          start of frame (only with i_in_valid), slot A
//            o_out_a..e     last complete frame, channels A..E
//            o_frame_valid  one-cycle pulse when o_out_a..e update
//            o_busy         a frame is partially collected
//            o_frame_err    one-cycle pulse when a partial frame is aborted
//            o_err_count    saturating aborted-frame count
// Options  : TDM_ERR_CNT_EN - builds the aborted-frame counter; when not
//            defined o_err_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_5ch #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     i_data_in,
    input  logic                 i_in_valid,
    input  logic                 i_sof,
    output logic [WIDTH-1:0]     o_out_a,
    output logic [WIDTH-1:0]     o_out_b,
    output logic [WIDTH-1:0]     o_out_c,
    output logic [WIDTH-1:0]     o_out_d,
    output logic [WIDTH-1:0]     o_out_e,
    output logic                 o_frame_valid,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic [ERR_CNT_W-1:0] o_err_count
);

    localparam logic [2:0] c_SLOT_A = 3'd0;
    localparam logic [2:0] c_SLOT_E = 3'd4;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_slot;
    logic [2:0] w_slot_nxt;
    logic       w_wr_en;
    logic [2:0] w_wr_idx;
    logic       w_commit;
    logic       w_abort;

    // Commit and abort are registered once so the frame publish / error
    // pulse land one cycle after the beat that triggered them.
    logic       r_commit_pend;
    logic       r_abort_pend;

    logic [WIDTH-1:0] r_shadow [0:4];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_slot        <= c_SLOT_A;
            r_commit_pend <= 1'b0;
            r_abort_pend  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_commit_pend <= w_commit;
            r_abort_pend  <= w_abort;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and shadow-write decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_wr_en     = 1'b0;
        w_wr_idx    = c_SLOT_A;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_slot_nxt = c_SLOT_A;
                if (i_in_valid && i_sof) begin
                    w_wr_en     = 1'b1;
                    w_wr_idx    = c_SLOT_A;
                    w_slot_nxt  = 3'd1;
                    w_state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (r_slot > c_SLOT_E) begin
                    // Out-of-range slot: recover to a clean idle.
                    w_slot_nxt  = c_SLOT_A;
                    w_state_nxt = S_IDLE;
                end else if (i_in_valid) begin
                    if (i_sof) begin
                        // Resync: this beat becomes slot A of a new frame.
                        w_abort    = 1'b1;
                        w_wr_en    = 1'b1;
                        w_wr_idx   = c_SLOT_A;
                        w_slot_nxt = 3'd1;
                    end else begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = r_slot;
                        if (r_slot == c_SLOT_E) begin
                            w_commit    = 1'b1;
                            w_slot_nxt  = c_SLOT_A;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_slot_nxt = r_slot + 3'd1;
                        end
                    end
                end
            end
            default: begin
                w_slot_nxt  = c_SLOT_A;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow registers, one per slot
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 5; gi++) begin : g_shadow
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_shadow[gi] <= '0;
            end else if (w_wr_en && (w_wr_idx == 3'(gi))) begin
                r_shadow[gi] <= i_data_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers. A slot-A capture for a back-to-back frame may
    // happen on the same edge as the publish; the publish reads the
    // pre-edge shadow value so the old frame stays intact.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_out_a       <= '0;
            o_out_b       <= '0;
            o_out_c       <= '0;
            o_out_d       <= '0;
            o_out_e       <= '0;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
        end else begin
            o_frame_valid <= r_commit_pend;
            o_frame_err   <= r_abort_pend;
            if (r_commit_pend) begin
                o_out_a <= r_shadow[0];
                o_out_b <= r_shadow[1];
                o_out_c <= r_shadow[2];
                o_out_d <= r_shadow[3];
                o_out_e <= r_shadow[4];
            end
        end
    end

    assign o_busy = (r_state == S_COLLECT);

    // ------------------------------------------------------------------
    // Aborted-frame counter (optional)
    // ------------------------------------------------------------------
`ifdef TDM_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    // Steps on the same edge that raises o_frame_err; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (r_abort_pend && (r_err_count != '1)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign o_err_count = r_err_count;
`else
    assign o_err_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_5ch.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_5ch
// Purpose  : Self-checking bench for tdm_demux_5ch. Directed beats are driven
//            from one initial block; each expected frame is pushed to a
//            scoreboard queue when its stimulus is driven and popped when the
//            DUT pulses frame_valid. Between pulses the outputs must hold the
//            last popped frame. Expected frame_err pulses are counted the
//            same way.
// Options  : TDM_ERR_CNT_EN - enables err_count value checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_5ch;

    localparam int WIDTH     = 4;
    localparam int ERR_CNT_W = 2;

    logic                 clk;
    logic                 reset;
    logic [WIDTH-1:0]     data_in;
    logic                 in_valid;
    logic                 sof;
    logic [WIDTH-1:0]     out_a, out_b, out_c, out_d, out_e;
    logic                 frame_valid;
    logic                 busy;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [5*WIDTH-1:0] exp_q [$];
    logic [5*WIDTH-1:0] last_frame;
    int                 err_pend;

    tdm_demux_5ch #(
        .WIDTH     (WIDTH),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_data_in     (data_in),
        .i_in_valid    (in_valid),
        .i_sof         (sof),
        .o_out_a       (out_a),
        .o_out_b       (out_b),
        .o_out_c       (out_c),
        .o_out_d       (out_d),
        .o_out_e       (out_e),
        .o_frame_valid (frame_valid),
        .o_busy        (busy),
        .o_frame_err   (frame_err),
        .o_err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [5*WIDTH-1:0] outs();
        return {out_a, out_b, out_c, out_d, out_e};
    endfunction

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] e);
        exp_q.push_back({a, b, c, d, e});
    endtask

    // Per-cycle scoreboard check, called after each active edge.
    task automatic monitor();
        if (frame_valid === 1'b1) begin
            chk("fv_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                last_frame = exp_q.pop_front();
                chk("frame", 32'(outs()), 32'(last_frame));
            end
        end else begin
            chk("hold", 32'(outs()), 32'(last_frame));
        end
        if (frame_err === 1'b1) begin
            chk("fe_expected", 32'(err_pend != 0), 32'd1);
            if (err_pend != 0) err_pend--;
        end
    endtask

    // Drive one beat just after a falling edge, let the DUT sample it,
    // then check on the next falling edge.
    task automatic step(input logic v, input logic s, input logic [3:0] d);
        in_valid = v;
        sof      = s;
        data_in  = d;
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        sof      = 1'b0;
        data_in  = '0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        last_frame = '0;
        err_pend   = 0;
        exp_q.delete();
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        sof        = 1'b0;
        data_in    = '0;
        last_frame = '0;
        err_pend   = 0;
        @(negedge clk);
        do_reset();

        // ---- reset state ----
        chk("rst_outs", 32'(outs()), 32'd0);
        chk("rst_fv", 32'(frame_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fe", 32'(frame_err), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);

        // ---- basic frame ----
        push(4'h8, 4'hF, 4'h3, 4'h2, 4'h5);
        step(1'b1, 1'b1, 4'h8); chk("t1_busy_b2", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 4'hF); chk("t1_busy_b3", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 4'h3); chk("t1_busy_b4", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 4'h2); chk("t1_busy_b5", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 4'h5);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_latency", 32'(frame_valid), 32'd0);
        step(1'b0, 1'b0, 4'h0);
        chk("t1_fv_pulse", 32'(frame_valid), 32'd1);
        idle(2);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // ---- gaps between beats ----
        push(4'h8, 4'hF, 4'h3, 4'h2, 4'h5);
        step(1'b1, 1'b1, 4'h8); idle(3);
        chk("t2_busy_gap", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 4'hF); idle(3);
        step(1'b1, 1'b0, 4'h3); idle(3);
        step(1'b1, 1'b0, 4'h2); idle(3);
        step(1'b1, 1'b0, 4'h5); idle(3);
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_outs", 32'(outs()), 32'h8F325);

        // ---- resync ----
        push(4'hA, 4'hB, 4'hC, 4'hD, 4'hE);
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 4'h3);
        err_pend++;
        step(1'b1, 1'b1, 4'hA);
        chk("t3_fe_latency", 32'(frame_err), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 4'hB);
        chk("t3_fe_pulse", 32'(frame_err), 32'd1);
        chk("t3_outs_kept", 32'(outs()), 32'h8F325);
        step(1'b1, 1'b0, 4'hC);
        step(1'b1, 1'b0, 4'hD);
        step(1'b1, 1'b0, 4'hE);
        idle(2);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);
        chk("t3_err_pend", 32'(err_pend), 32'd0);
        chk("t3_outs", 32'(outs()), 32'hABCDE);
`ifdef TDM_ERR_CNT_EN
        chk("t3_errcnt", 32'(err_count), 32'd1);
`else
        chk("t3_errcnt", 32'(err_count), 32'd0);
`endif

        // ---- idle garbage and back-to-back ----
        do_reset();
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h7);
        step(1'b0, 1'b1, 4'h9);   // sof without valid is ignored
        chk("t4_garbage_outs", 32'(outs()), 32'd0);
        chk("t4_garbage_busy", 32'(busy), 32'd0);
        push(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
        push(4'h6, 4'h7, 4'h8, 4'h9, 4'hA);
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        step(1'b1, 1'b0, 4'h3);
        step(1'b1, 1'b0, 4'h4);
        step(1'b1, 1'b0, 4'h5);
        step(1'b1, 1'b1, 4'h6);
        chk("t4_b2b_fv", 32'(frame_valid), 32'd1);
        chk("t4_b2b_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b0, 4'h7);
        step(1'b1, 1'b0, 4'h8);
        step(1'b1, 1'b0, 4'h9);
        step(1'b1, 1'b0, 4'hA);
        idle(2);
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        chk("t4_outs", 32'(outs()), 32'h6789A);

        // ---- reset mid-frame ----
        step(1'b1, 1'b1, 4'hC);
        step(1'b1, 1'b0, 4'hD);
        step(1'b1, 1'b0, 4'hE);
        reset = 1'b1;
        #1;
        chk("t5_async_outs", 32'(outs()), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_fe", 32'(frame_err), 32'd0);
        do_reset();
        push(4'h3, 4'h1, 4'h4, 4'h1, 4'h5);
        step(1'b1, 1'b1, 4'h3);
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h4);
        step(1'b1, 1'b0, 4'h1);
        step(1'b1, 1'b0, 4'h5);
        idle(2);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        chk("t5_outs", 32'(outs()), 32'h31415);
        chk("t5_err_pend", 32'(err_pend), 32'd0);

        // ---- five aborted frames ----
        step(1'b1, 1'b1, 4'h1);
        step(1'b1, 1'b0, 4'h2);
        for (int k = 0; k < 5; k++) begin
            err_pend++;
            step(1'b1, 1'b1, 4'h1);
            step(1'b1, 1'b0, 4'h2);
        end
        idle(3);
        chk("t6_err_pend", 32'(err_pend), 32'd0);
        chk("t6_outs_kept", 32'(outs()), 32'h31415);
`ifdef TDM_ERR_CNT_EN
        chk("t6_errcnt_sat", 32'(err_count), 32'd3);
        idle(2);
        chk("t6_errcnt_hold", 32'(err_count), 32'd3);
`else
        chk("t6_errcnt", 32'(err_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
